// File: rtl/iob_eth_defs.sv
// Shared definitions for the Ethernet RX status path: FSM encoding, default
// length limits, CRC residue and EtherType byte offsets.
package iob_eth_defs;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    EVAL = 2'd2,
    HOLD = 2'd3
  } rx_state_t;

  localparam int          DEF_MIN_LEN     = 64;
  localparam int          DEF_MAX_LEN     = 1518;
  localparam logic [31:0] DEF_CRC_RESIDUE = 32'hC704DD7B;

  localparam logic [10:0] ETHERTYPE_HI_ADDR = 11'd12;
  localparam logic [10:0] ETHERTYPE_LO_ADDR = 11'd13;
  localparam logic [10:0] BYTE_CNT_MAX      = 11'd2047;

endpackage

// File: rtl/iob_eth_sat_cnt.sv
// 16-bit statistics counter that sticks at 16'hFFFF; cleared only by reset.
module iob_eth_sat_cnt (
  input  logic        RX_CLK,
  input  logic        rst,
  input  logic        inc,
  output logic [15:0] cnt
);

  always_ff @(posedge RX_CLK or posedge rst) begin
    if (rst) begin
      cnt <= 16'd0;
    end else if (inc && (cnt != 16'hFFFF)) begin
      cnt <= cnt + 16'd1;
    end
  end

endmodule

// File: rtl/iob_eth_rx_status.sv
// Per-frame RX status record (length, CRC verdict, length errors, EtherType,
// overrun) under a valid/ack handshake. Statistics built with IOB_ETH_RX_STATS_EN.
module iob_eth_rx_status
  import iob_eth_defs::*;
#(
  parameter int          MIN_LEN     = DEF_MIN_LEN,
  parameter int          MAX_LEN     = DEF_MAX_LEN,
  parameter logic [31:0] CRC_RESIDUE = DEF_CRC_RESIDUE
) (
  input  logic        rst,
  input  logic        RX_CLK,
  input  logic        RX_DV,
  input  logic        wr,
  input  logic [10:0] addr,
  input  logic [7:0]  data,
  input  logic [31:0] crc_value,
  output logic        status_valid,
  input  logic        status_ack,
  output logic [10:0] status_len,
  output logic        status_crc_ok,
  output logic        status_short,
  output logic        status_long,
  output logic        status_overrun,
  output logic [15:0] status_ethertype,
  output logic [15:0] good_cnt,
  output logic [15:0] bad_cnt,
  output logic [15:0] drop_cnt
);

  localparam logic [10:0] MIN_LEN_W = 11'(MIN_LEN);
  localparam logic [10:0] MAX_LEN_W = 11'(MAX_LEN);

  rx_state_t   state, next_state;
  logic        eval_second;
  logic [10:0] byte_cnt;
  logic [15:0] ethertype;
  logic        overrun_flag;
  logic        frame_start;
  logic        capture;
  logic        drop;
  logic        crc_ok_now, short_now, long_now;

  assign frame_start = wr && (addr == 11'd0);
  assign crc_ok_now  = (crc_value == CRC_RESIDUE);
  assign short_now   = (byte_cnt < MIN_LEN_W);
  assign long_now    = (byte_cnt > MAX_LEN_W);

  always_ff @(posedge RX_CLK or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    capture    = 1'b0;
    drop       = 1'b0;
    case (state)
      IDLE: if (frame_start) next_state = RECV;
      RECV: if (!RX_DV) next_state = EVAL;
      EVAL: begin
        if (eval_second) begin
          capture    = 1'b1;
          next_state = HOLD;
        end
      end
      HOLD: begin
        drop = frame_start;
        if (status_ack) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Frame accumulation: byte count, EtherType halves, and the two-cycle EVAL phase.
  always_ff @(posedge RX_CLK or posedge rst) begin
    if (rst) begin
      byte_cnt    <= 11'd0;
      ethertype   <= 16'd0;
      eval_second <= 1'b0;
    end else begin
      eval_second <= (state == EVAL) ? ~eval_second : 1'b0;
      if (state == IDLE && frame_start) begin
        byte_cnt  <= 11'd1;
        ethertype <= 16'd0;
      end else if (state == RECV && wr) begin
        if (byte_cnt != BYTE_CNT_MAX) byte_cnt <= byte_cnt + 11'd1;
        if (addr == ETHERTYPE_HI_ADDR) ethertype[15:8] <= data;
        if (addr == ETHERTYPE_LO_ADDR) ethertype[7:0]  <= data;
      end
    end
  end

  always_ff @(posedge RX_CLK or posedge rst) begin
    if (rst) begin
      overrun_flag     <= 1'b0;
      status_valid     <= 1'b0;
      status_len       <= 11'd0;
      status_crc_ok    <= 1'b0;
      status_short     <= 1'b0;
      status_long      <= 1'b0;
      status_overrun   <= 1'b0;
      status_ethertype <= 16'd0;
    end else begin
      if (capture)   overrun_flag <= 1'b0;
      else if (drop) overrun_flag <= 1'b1;
      if (capture) begin
        status_valid     <= 1'b1;
        status_len       <= byte_cnt;
        status_crc_ok    <= crc_ok_now;
        status_short     <= short_now;
        status_long      <= long_now;
        status_overrun   <= overrun_flag;
        status_ethertype <= ethertype;
      end else if (state == HOLD && status_ack) begin
        status_valid <= 1'b0;
      end
    end
  end

`ifdef IOB_ETH_RX_STATS_EN
  logic frame_good;
  assign frame_good = crc_ok_now && !short_now && !long_now;

  iob_eth_sat_cnt u_good_cnt (.RX_CLK(RX_CLK), .rst(rst), .inc(capture && frame_good),  .cnt(good_cnt));
  iob_eth_sat_cnt u_bad_cnt  (.RX_CLK(RX_CLK), .rst(rst), .inc(capture && !frame_good), .cnt(bad_cnt));
  iob_eth_sat_cnt u_drop_cnt (.RX_CLK(RX_CLK), .rst(rst), .inc(drop),                   .cnt(drop_cnt));
`else
  assign good_cnt = 16'd0;
  assign bad_cnt  = 16'd0;
  assign drop_cnt = 16'd0;
`endif

endmodule

// File: doc/iob_eth_rx_status.md
# iob_eth_rx_status

Frame-status stage in the RX_CLK domain, directly downstream of the Ethernet receiver. It watches the receiver's byte-write stream (addr/data/wr), its running CRC and RX_DV, and detects end of frame. For each frame it produces one status record: length, CRC verdict, length violations, EtherType and overrun. The record is held under a valid/ack handshake until software-side logic consumes it.

## Interface
Parameters:
- MIN_LEN, 64: minimum legal frame length in bytes, from first destination-MAC byte through FCS.
- MAX_LEN, 1518: maximum legal frame length, same counting.
- CRC_RESIDUE, 32'hC704DD7B: crc_value expected after the FCS has been fed through the CRC.

Ports:
- rst  in  1  asynchronous reset, active-high
- RX_CLK  in  1  receive clock
- RX_DV  in  1  MII data valid
- wr  in  1  receiver byte-write strobe
- addr  in  11  receiver byte address
- data  in  8  receiver byte
- crc_value  in  32  receiver running CRC
- status_valid  out  1  status record available
- status_ack  in  1  consume record; RX_CLK domain, single-cycle pulse
- status_len  out  11  frame byte count
- status_crc_ok  out  1  crc_value equalled CRC_RESIDUE
- status_short  out  1  len < MIN_LEN
- status_long  out  1  len > MAX_LEN (includes saturation)
- status_overrun  out  1  one or more frames dropped since the previous record
- status_ethertype  out  16  bytes 12 (MSB) and 13 (LSB)
- good_cnt, bad_cnt, drop_cnt  out  16 each  statistics (see Configuration)

## Operation
- FSM states: IDLE, RECV, EVAL, HOLD.
- IDLE:
  - wr && addr==0 -> RECV with byte_cnt=1.
  - wr with addr!=0 is ignored.
- RECV:
  - Each wr increments byte_cnt. The count saturates at 2047.
  - wr at addr 12 loads ethertype[15:8]; wr at addr 13 loads ethertype[7:0].
  - RX_DV low -> EVAL.
- EVAL:
  - Lasts exactly 2 cycles so that the CRC of the last byte settles.
  - On the 2nd cycle: all status outputs are registered from byte_cnt, crc_value and the sticky overrun flag; the overrun flag is cleared; the state goes to HOLD.
- HOLD:
  - status_valid=1 and the outputs are stable.
  - status_ack -> IDLE, status_valid=0.
  - wr && addr==0 while in HOLD drops that frame and sets the sticky overrun flag; the dropped frame is never reported.
- A frame is good when crc_ok && !short && !long. Any other frame is bad.
- ethertype is 0 if the frame ended before byte 13. Unwritten halves read 0 and are cleared on entry to RECV.
- Reset value of every output is 0. Internal state resets to IDLE and all counters to 0.

## Timing
- status_valid rises 2 cycles after the first RX_CLK edge that samples RX_DV low in RECV.
- status_ack is honoured only in HOLD and ignored elsewhere. Deassertion of status_valid is visible the cycle after ack.
- status_ack and a new frame start in the same HOLD cycle: ack wins, the state goes to IDLE, and that frame is dropped with overrun set. It is not captured, because its addr==0 write has already passed.
- Reset asserted mid-frame: immediate return to IDLE, no record, partial frame lost.
- RX_DV glitch low for one cycle during RECV ends the frame. The remainder then appears as a new frame only if addr restarts at 0.

## Configuration
- IOB_ETH_RX_STATS_EN defined:
  - good_cnt/bad_cnt increment on entry to HOLD.
  - drop_cnt increments on each dropped frame.
  - All three saturate at 16'hFFFF and clear only on reset.
- Undefined: the counter registers are not built and the three ports are tied to 0.

## Structure
- Shared package/header (iob_eth_defs): FSM state encodings, default MIN_LEN/MAX_LEN, CRC_RESIDUE, ETHERTYPE byte offsets 12/13.
- One sub-module: iob_eth_sat_cnt, a 16-bit saturating counter with inc input, instantiated three times under IOB_ETH_RX_STATS_EN.

## Test plan
- 64-byte frame with correct FCS, EtherType 0x0800 -> status_len=64, crc_ok=1, short=0, long=0, ethertype=16'h0800, good_cnt=1.
- 64-byte frame with FCS byte 63 flipped -> crc_ok=0, bad_cnt=1, good_cnt unchanged.
- 60-byte frame with valid CRC -> short=1, counted bad. 1519-byte frame -> long=1. 2100-byte frame -> len=2047, long=1.
- Two frames back-to-back with no ack -> 1st record held unchanged, drop_cnt=1. After ack, the 3rd frame's record has status_overrun=1; the following record has overrun=0.
- Reset asserted at byte 30 of a frame -> all outputs 0, no status_valid. The next 64-byte good frame reports normally.
- Build without IOB_ETH_RX_STATS_EN, repeat the first scenario -> same status fields, good_cnt/bad_cnt/drop_cnt stay 0.
